// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared size codes, R_W polarity and FSM encodings for the
//            handshake memory.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_byte_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_array
// Brief    : Byte-wide storage with big-endian 1/2/4-lane synchronous write
//            and a combinational 4-byte read, both wrapping at the top.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [7:0]            r_mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] w_lane_addr [4];

    // Lane 0 is the most significant byte; lane addresses wrap naturally.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_lane_addr[i]      = i_addr + ADDR_WIDTH'(i);
        assign o_rdata[31-8*i -: 8] = r_mem[w_lane_addr[i]];
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            case (i_size)
                TYPE_BYTE: r_mem[w_lane_addr[0]] <= i_wdata[7:0];
                TYPE_HALF: begin
                    r_mem[w_lane_addr[0]] <= i_wdata[15:8];
                    r_mem[w_lane_addr[1]] <= i_wdata[7:0];
                end
                TYPE_WORD: begin
                    r_mem[w_lane_addr[0]] <= i_wdata[31:24];
                    r_mem[w_lane_addr[1]] <= i_wdata[23:16];
                    r_mem[w_lane_addr[2]] <= i_wdata[15:8];
                    r_mem[w_lane_addr[3]] <= i_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule : mem_byte_array
`default_nettype wire

// File: rtl/mem_handshake_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_handshake_ram
// Brief    : Big-endian byte-addressable memory answering MOV/MOC requests
//            after a fixed latency, flagging misaligned/illegal accesses on Err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_handshake_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MOV,
    input  logic        R_W,
    input  logic [1:0]  Type,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err
);

    localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic [1:0]            r_type;
    logic                  r_rw;

    logic                  w_misalign;
    logic                  w_done;
    logic                  w_we;
    logic [31:0]           w_rdata;
    logic [31:0]           w_rd_fmt;
    logic                  w_addr_unused;

    // Upper address bits are deliberately ignored so accesses wrap.
    assign w_addr_unused = ^Address[31:ADDR_WIDTH];

    always_comb begin
        w_misalign = 1'b0;
        case (r_type)
            TYPE_BYTE: w_misalign = 1'b0;
            TYPE_HALF: w_misalign = r_addr[0];
            TYPE_WORD: w_misalign = |r_addr[1:0];
            default:   w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_fmt = w_rdata;
        case (r_type)
            TYPE_BYTE: w_rd_fmt = {24'h0, w_rdata[31:24]};
            TYPE_HALF: w_rd_fmt = {16'h0, w_rdata[31:16]};
            default:   w_rd_fmt = w_rdata;
        endcase
    end

    assign w_done = (r_state == WAIT) && (r_cnt == 4'd0);
    // Gating with Clr keeps a reset coincident with the completing edge from committing the write.
    assign w_we   = w_done && !w_misalign && (r_rw == RW_WRITE) && !Clr;

    mem_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_size  (r_type),
        .i_addr  (r_addr),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= 32'h0;
            r_type  <= TYPE_BYTE;
            r_rw    <= RW_READ;
            MOC     <= 1'b0;
            Err     <= 1'b0;
            DataOut <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MOV) begin
                        r_addr  <= Address[ADDR_WIDTH-1:0];
                        r_data  <= DataIn;
                        r_type  <= Type;
                        r_rw    <= R_W;
                        r_cnt   <= c_lat_load;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        MOC     <= 1'b1;
                        Err     <= w_misalign;
                        r_state <= DONE;
                        if (!w_misalign && r_rw == RW_READ) begin
                            DataOut <= w_rd_fmt;
                        end
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        MOC     <= 1'b0;
                        Err     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : mem_handshake_ram
`default_nettype wire

// File: tb/tb_mem_handshake_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_handshake_ram
// Brief    : Directed self-checking bench for the MOV/MOC handshake memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_handshake_ram;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        MOV;
    logic        R_W;
    logic [1:0]  Type;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    mem_handshake_ram #(
        .ADDR_WIDTH (9),
        .LATENCY    (2)
    ) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .MOV     (MOV),
        .R_W     (R_W),
        .Type    (Type),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC),
        .Err     (Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full handshake; inputs are scrambled after acceptance to prove they are latched.
    task automatic access(input string tag, input logic rw, input logic [1:0] ty,
                          input logic [31:0] addr, input logic [31:0] din,
                          output logic [31:0] dout, output logic err);
        int n;
        @(posedge Clk); #1;
        MOV = 1'b1; R_W = rw; Type = ty; Address = addr; DataIn = din;
        @(posedge Clk); #1;
        R_W = ~rw; Type = ~ty; Address = ~addr; DataIn = ~din;
        n = 0;
        while (!MOC && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 2);
        dout = DataOut;
        err  = Err;
        @(posedge Clk); #1;
        check({tag, "_moc_hold"}, {31'h0, MOC}, 1);
        check({tag, "_dout_hold"}, DataOut, dout);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check({tag, "_moc_drop"}, {31'h0, MOC}, 0);
        check({tag, "_err_drop"}, {31'h0, Err}, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          n;

        Clr = 1'b1; MOV = 1'b0; R_W = 1'b1; Type = 2'b00; Address = 32'h0; DataIn = 32'h0;
        @(posedge Clk); #1;
        check("rst_moc", {31'h0, MOC}, 0);
        check("rst_err", {31'h0, Err}, 0);
        check("rst_dout", DataOut, 32'h0);
        @(posedge Clk); #1;
        Clr = 1'b0;

        // 1: word write
        access("wr_word", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, d, e);
        check("wr_word_err", {31'h0, e}, 0);
        check("wr_word_dout", d, 32'h0);

        // 2: sized reads
        access("rd_word", 1'b1, 2'b10, 32'h10, 32'h0, d, e);
        check("rd_word_val", d, 32'hDEADBEEF);
        check("rd_word_err", {31'h0, e}, 0);
        access("rd_byte", 1'b1, 2'b00, 32'h11, 32'h0, d, e);
        check("rd_byte_val", d, 32'h000000AD);
        check("rd_byte_err", {31'h0, e}, 0);
        access("rd_half", 1'b1, 2'b01, 32'h12, 32'h0, d, e);
        check("rd_half_val", d, 32'h0000BEEF);
        check("rd_half_err", {31'h0, e}, 0);

        // 3: byte write then word read
        access("wr_byte", 1'b0, 2'b00, 32'h13, 32'h12345677, d, e);
        check("wr_byte_dout", d, 32'h0000BEEF);
        access("rd_after_byte", 1'b1, 2'b10, 32'h10, 32'h0, d, e);
        check("rd_after_byte_val", d, 32'hDEADBE77);

        // 4: misaligned / illegal
        access("rd_misal", 1'b1, 2'b10, 32'h12, 32'h0, d, e);
        check("rd_misal_err", {31'h0, e}, 1);
        check("rd_misal_dout", d, 32'hDEADBE77);
        access("rd_ill", 1'b1, 2'b11, 32'h10, 32'h0, d, e);
        check("rd_ill_err", {31'h0, e}, 1);
        access("wr_misal", 1'b0, 2'b01, 32'h11, 32'h0000FFFF, d, e);
        check("wr_misal_err", {31'h0, e}, 1);
        access("rd_post_err", 1'b1, 2'b10, 32'h10, 32'h0, d, e);
        check("rd_post_err_val", d, 32'hDEADBE77);
        check("rd_post_err_err", {31'h0, e}, 0);

        // 5: reset aborts a pending write
        access("wr_prior", 1'b0, 2'b10, 32'h20, 32'h11223344, d, e);
        @(posedge Clk); #1;
        MOV = 1'b1; R_W = 1'b0; Type = 2'b10; Address = 32'h20; DataIn = 32'hCAFEF00D;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Clr = 1'b1;
        #1;
        check("clr_moc", {31'h0, MOC}, 0);
        check("clr_err", {31'h0, Err}, 0);
        check("clr_dout", DataOut, 32'h0);
        MOV = 1'b0;
        @(posedge Clk); #1;
        Clr = 1'b0;
        access("rd_after_clr", 1'b1, 2'b10, 32'h20, 32'h0, d, e);
        check("rd_after_clr_val", d, 32'h11223344);

        // 6: wrap and short MOV
        access("rd_wrap", 1'b1, 2'b10, 32'h210, 32'h0, d, e);
        check("rd_wrap_val", d, 32'hDEADBE77);
        access("wr_half", 1'b0, 2'b01, 32'h20, 32'h0000A5C3, d, e);
        access("rd_half_wr", 1'b1, 2'b10, 32'h20, 32'h0, d, e);
        check("rd_half_wr_val", d, 32'hA5C33344);

        @(posedge Clk); #1;
        MOV = 1'b1; R_W = 1'b1; Type = 2'b00; Address = 32'h12;
        @(posedge Clk); #1;
        MOV = 1'b0;
        n = 0;
        while (!MOC && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        check("short_latency", n, 2);
        check("short_dout", DataOut, 32'h000000BE);
        @(posedge Clk); #1;
        check("short_moc_pulse", {31'h0, MOC}, 0);
        @(posedge Clk); #1;
        check("short_idle", {31'h0, MOC}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_handshake_ram
`default_nettype wire
